// File: rtl/mem_arb_pkg.sv
// Shared constants for the fetch/data memory arbiter: FSM state encodings,
// owner identifiers and default widths.
package mem_arb_pkg;

   localparam int ADDR_W_DEF       = 32;
   localparam int DATA_W_DEF       = 32;
   localparam int STARVE_LIMIT_DEF = 4;
   localparam int TIMEOUT_CYC_DEF  = 255;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_ISSUE = 2'd1;
   localparam state_t ST_WAIT  = 2'd2;
   localparam state_t ST_RESP  = 2'd3;

   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_DM = 1'b1;

endpackage

// File: rtl/mem_arb_prio.sv
// Grant selection between fetch and data requesters: data wins unless fetch
// has been passed over STARVE_LIMIT times in a row.
module mem_arb_prio
   import mem_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic if_req,
   input  logic dm_req,
   input  logic arb_en,
   output logic grant_own
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0] starve_q;
   logic [3:0] starve_d;
   logic       fetch_starved;

   assign fetch_starved = if_req && (starve_q == LIMIT);

   always_comb begin
      grant_own = OWN_IF;
      if (dm_req && !fetch_starved) begin
         grant_own = OWN_DM;
      end
   end

   // Counter only moves on an actual grant; it saturates so a stuck data
   // requester cannot wrap it back below the limit.
   always_comb begin
      starve_d = starve_q;
      if (arb_en) begin
         if (grant_own == OWN_IF) begin
            starve_d = '0;
         end else if (if_req && (starve_q != LIMIT)) begin
            starve_d = starve_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for the IF and MEM stages of the core.
// Optional transaction timeout enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int DATA_W       = DATA_W_DEF,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
   parameter int TIMEOUT_CYC  = TIMEOUT_CYC_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   output logic              if_stall,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_ack,
   output logic              dm_stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              timeout_err
);

   state_t            state_q, state_d;
   logic              own_q, own_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              mem_req_q, mem_req_d;
   logic              if_ack_q, if_ack_d;
   logic              dm_ack_q, dm_ack_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
   logic              grant_own;
   logic              arb_en;
   logic              tmo_hit;

   assign arb_en = (state_q == ST_IDLE) && (if_req || dm_req);

   mem_arb_prio #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_prio (
      .clk      (clk),
      .reset    (reset),
      .if_req   (if_req),
      .dm_req   (dm_req),
      .arb_en   (arb_en),
      .grant_own(grant_own)
   );

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int TMO_W = (TIMEOUT_CYC > 255) ? $clog2(TIMEOUT_CYC + 1) : 8;

   logic [TMO_W-1:0] tmo_cnt_q;
   logic             tmo_err_q;
   logic             in_flight;

   assign in_flight = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
   // A response arriving on the last allowed cycle still completes normally.
   assign tmo_hit   = in_flight && (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1))
                      && !((state_q == ST_WAIT) && mem_rvalid);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmo_cnt_q <= '0;
         tmo_err_q <= 1'b0;
      end else begin
         if (state_q == ST_IDLE) begin
            tmo_cnt_q <= '0;
         end else if (in_flight) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
         end
         if (tmo_hit) begin
            tmo_err_q <= 1'b1;
         end
      end
   end

   assign timeout_err = tmo_err_q;
`else
   assign tmo_hit     = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      own_d      = own_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      mem_req_d  = mem_req_q;
      if_ack_d   = 1'b0;
      dm_ack_d   = 1'b0;
      if_rdata_d = '0;
      dm_rdata_d = '0;
      case (state_q)
         ST_IDLE: begin
            if (arb_en) begin
               own_d     = grant_own;
               mem_req_d = 1'b1;
               state_d   = ST_ISSUE;
               if (grant_own == OWN_DM) begin
                  we_d    = dm_we;
                  addr_d  = dm_addr;
                  wdata_d = dm_wdata;
               end else begin
                  we_d    = 1'b0;
                  addr_d  = if_addr;
                  wdata_d = '0;
               end
            end
         end
         ST_ISSUE: begin
            if (mem_ready) begin
               mem_req_d = 1'b0;
               state_d   = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (mem_rvalid) begin
               state_d = ST_RESP;
               if (own_q == OWN_DM) begin
                  dm_ack_d   = 1'b1;
                  dm_rdata_d = we_q ? '0 : mem_rdata;
               end else begin
                  if_ack_d   = 1'b1;
                  if_rdata_d = mem_rdata;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // Abort: ack the owner with zero data so the stalled stage can move on.
      if (tmo_hit) begin
         state_d    = ST_RESP;
         mem_req_d  = 1'b0;
         if_ack_d   = (own_q == OWN_IF);
         dm_ack_d   = (own_q == OWN_DM);
         if_rdata_d = '0;
         dm_rdata_d = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         own_q      <= OWN_IF;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         mem_req_q  <= 1'b0;
         if_ack_q   <= 1'b0;
         dm_ack_q   <= 1'b0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         own_q      <= own_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         mem_req_q  <= mem_req_d;
         if_ack_q   <= if_ack_d;
         dm_ack_q   <= dm_ack_d;
         if_rdata_q <= if_rdata_d;
         dm_rdata_q <= dm_rdata_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign if_ack    = if_ack_q;
   assign dm_ack    = dm_ack_q;
   assign if_rdata  = if_rdata_q;
   assign dm_rdata  = dm_rdata_q;
   assign if_stall  = if_req & ~if_ack_q;
   assign dm_stall  = dm_req & ~dm_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; the timeout scenario
// follows the MEM_ARB_TIMEOUT_EN build setting.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        if_stall;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_ack;
   logic        dm_stall;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        timeout_err;

   int testsRun = 0;
   int failCount = 0;

   mem_arbiter #(
      .ADDR_W      (32),
      .DATA_W      (32),
      .STARVE_LIMIT(4),
      .TIMEOUT_CYC (8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .if_req     (if_req),
      .if_addr    (if_addr),
      .if_rdata   (if_rdata),
      .if_ack     (if_ack),
      .if_stall   (if_stall),
      .dm_req     (dm_req),
      .dm_we      (dm_we),
      .dm_addr    (dm_addr),
      .dm_wdata   (dm_wdata),
      .dm_rdata   (dm_rdata),
      .dm_ack     (dm_ack),
      .dm_stall   (dm_stall),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_ready  (mem_ready),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   // Memory-side inputs for the cycle are applied mid-cycle, outputs sampled 1 time unit later.
   task automatic applyStimulus(input logic ready, input logic rvalid, input logic [31:0] rdata);
      @(negedge clk);
      mem_ready  = ready;
      mem_rvalid = rvalid;
      mem_rdata  = rdata;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   initial begin
      logic ownIf;
      reset      = 1'b1;
      if_req     = 1'b0;
      if_addr    = '0;
      dm_req     = 1'b0;
      dm_we      = 1'b0;
      dm_addr    = '0;
      dm_wdata   = '0;
      mem_ready  = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;

      applyStimulus(0, 0, 0);
      applyStimulus(0, 0, 0);
      checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
      checkOutput("rst_mem_addr", mem_addr, 32'd0);
      checkOutput("rst_if_ack", 32'(if_ack), 32'd0);
      checkOutput("rst_dm_ack", 32'(dm_ack), 32'd0);
      checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
      reset = 1'b0;

      $display("[TB] lone fetch");
      applyStimulus(0, 0, 0);
      if_req  = 1'b1;
      if_addr = 32'h0000_0010;
      #1;
      checkOutput("f_c0_if_stall", 32'(if_stall), 32'd1);
      checkOutput("f_c0_mem_req", 32'(mem_req), 32'd0);
      applyStimulus(1, 0, 0);
      checkOutput("f_c1_mem_req", 32'(mem_req), 32'd1);
      checkOutput("f_c1_mem_addr", mem_addr, 32'h10);
      checkOutput("f_c1_mem_we", 32'(mem_we), 32'd0);
      applyStimulus(0, 1, 32'h13);
      checkOutput("f_c2_mem_req", 32'(mem_req), 32'd0);
      checkOutput("f_c2_if_ack", 32'(if_ack), 32'd0);
      applyStimulus(0, 0, 0);
      checkOutput("f_c3_if_ack", 32'(if_ack), 32'd1);
      checkOutput("f_c3_if_rdata", if_rdata, 32'h13);
      checkOutput("f_c3_dm_ack", 32'(dm_ack), 32'd0);
      checkOutput("f_c3_if_stall", 32'(if_stall), 32'd0);
      if_req = 1'b0;
      applyStimulus(0, 0, 0);
      checkOutput("f_c4_if_ack", 32'(if_ack), 32'd0);
      checkOutput("f_c4_if_rdata", if_rdata, 32'd0);
      checkOutput("f_c4_dm_ack", 32'(dm_ack), 32'd0);

      $display("[TB] data write with ready stall");
      dm_req   = 1'b1;
      dm_we    = 1'b1;
      dm_addr  = 32'h100;
      dm_wdata = 32'hDEAD_BEEF;
      applyStimulus(0, 0, 0);
      checkOutput("w_c1_mem_req", 32'(mem_req), 32'd1);
      checkOutput("w_c1_mem_we", 32'(mem_we), 32'd1);
      checkOutput("w_c1_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      applyStimulus(0, 0, 0);
      checkOutput("w_c2_mem_req", 32'(mem_req), 32'd1);
      applyStimulus(1, 0, 0);
      checkOutput("w_c3_mem_req", 32'(mem_req), 32'd1);
      checkOutput("w_c3_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      checkOutput("w_c3_mem_addr", mem_addr, 32'h100);
      applyStimulus(0, 1, 32'h55);
      checkOutput("w_c4_mem_req", 32'(mem_req), 32'd0);
      checkOutput("w_c4_dm_ack", 32'(dm_ack), 32'd0);
      checkOutput("w_c4_dm_stall", 32'(dm_stall), 32'd1);
      applyStimulus(0, 0, 0);
      checkOutput("w_c5_dm_ack", 32'(dm_ack), 32'd1);
      checkOutput("w_c5_dm_rdata", dm_rdata, 32'd0);
      checkOutput("w_c5_dm_stall", 32'(dm_stall), 32'd0);
      dm_req = 1'b0;
      dm_we  = 1'b0;
      applyStimulus(0, 0, 0);
      checkOutput("w_c6_dm_ack", 32'(dm_ack), 32'd0);

      $display("[TB] starvation rotation");
      if_req  = 1'b1;
      if_addr = 32'h40;
      dm_req  = 1'b1;
      dm_addr = 32'h200;
      for (int t = 0; t < 10; t++) begin
         ownIf = ((t % 5) == 4);
         applyStimulus(1, 0, 0);
         checkOutput($sformatf("s%0d_mem_addr", t), mem_addr, ownIf ? 32'h40 : 32'h200);
         applyStimulus(0, 1, 32'(t) + 32'hA0);
         applyStimulus(0, 0, 0);
         checkOutput($sformatf("s%0d_if_ack", t), 32'(if_ack), 32'(ownIf));
         checkOutput($sformatf("s%0d_dm_ack", t), 32'(dm_ack), 32'(!ownIf));
         checkOutput($sformatf("s%0d_if_stall", t), 32'(if_stall), 32'(!ownIf));
         checkOutput($sformatf("s%0d_rdata", t), ownIf ? if_rdata : dm_rdata, 32'(t) + 32'hA0);
         if (t == 9) begin
            if_req = 1'b0;
            dm_req = 1'b0;
         end
         applyStimulus(0, 0, 0);
         checkOutput($sformatf("s%0d_idle_if_stall", t), 32'(if_stall), 32'(t != 9));
      end

      $display("[TB] simultaneous request, loser next");
      if_req  = 1'b1;
      if_addr = 32'h44;
      dm_req  = 1'b1;
      dm_addr = 32'h300;
      applyStimulus(1, 0, 0);
      checkOutput("x_c1_mem_addr", mem_addr, 32'h300);
      applyStimulus(0, 1, 32'hAA);
      applyStimulus(0, 0, 0);
      checkOutput("x_c3_dm_ack", 32'(dm_ack), 32'd1);
      checkOutput("x_c3_dm_rdata", dm_rdata, 32'hAA);
      checkOutput("x_c3_if_stall", 32'(if_stall), 32'd1);
      dm_req = 1'b0;
      applyStimulus(0, 0, 0);
      checkOutput("x_c4_mem_req", 32'(mem_req), 32'd0);
      checkOutput("x_c4_dm_stall", 32'(dm_stall), 32'd0);
      applyStimulus(1, 0, 0);
      checkOutput("x_c5_mem_req", 32'(mem_req), 32'd1);
      checkOutput("x_c5_mem_addr", mem_addr, 32'h44);
      applyStimulus(0, 1, 32'hBB);
      applyStimulus(0, 0, 0);
      checkOutput("x_c7_if_ack", 32'(if_ack), 32'd1);
      checkOutput("x_c7_if_rdata", if_rdata, 32'hBB);
      checkOutput("x_c7_dm_ack", 32'(dm_ack), 32'd0);
      if_req = 1'b0;
      applyStimulus(0, 0, 0);
      checkOutput("x_c8_mem_req", 32'(mem_req), 32'd0);

      $display("[TB] reset during WAIT");
      if_req  = 1'b1;
      if_addr = 32'h80;
      applyStimulus(1, 0, 0);
      checkOutput("r_c1_mem_req", 32'(mem_req), 32'd1);
      applyStimulus(0, 0, 0);
      reset  = 1'b1;
      if_req = 1'b0;
      #1;
      checkOutput("r_rst_mem_req", 32'(mem_req), 32'd0);
      checkOutput("r_rst_mem_addr", mem_addr, 32'd0);
      checkOutput("r_rst_if_ack", 32'(if_ack), 32'd0);
      applyStimulus(0, 1, 32'h77);
      reset = 1'b0;
      #1;
      checkOutput("r_late_if_ack", 32'(if_ack), 32'd0);
      applyStimulus(0, 0, 0);
      checkOutput("r_post_if_ack", 32'(if_ack), 32'd0);
      checkOutput("r_post_if_rdata", if_rdata, 32'd0);
      checkOutput("r_post_mem_req", 32'(mem_req), 32'd0);
      if_req  = 1'b1;
      if_addr = 32'h84;
      applyStimulus(1, 0, 0);
      checkOutput("r_next_mem_addr", mem_addr, 32'h84);
      applyStimulus(0, 1, 32'h99);
      applyStimulus(0, 0, 0);
      checkOutput("r_next_if_ack", 32'(if_ack), 32'd1);
      checkOutput("r_next_if_rdata", if_rdata, 32'h99);
      if_req = 1'b0;
      applyStimulus(0, 0, 0);

      $display("[TB] unresponsive memory");
      dm_req  = 1'b1;
      dm_we   = 1'b0;
      dm_addr = 32'h400;
      for (int c = 1; c <= 8; c++) begin
         applyStimulus(0, 0, 0);
         checkOutput($sformatf("t_c%0d_mem_req", c), 32'(mem_req), 32'd1);
         checkOutput($sformatf("t_c%0d_dm_ack", c), 32'(dm_ack), 32'd0);
      end
`ifdef MEM_ARB_TIMEOUT_EN
      applyStimulus(0, 0, 0);
      checkOutput("t_c9_dm_ack", 32'(dm_ack), 32'd1);
      checkOutput("t_c9_dm_rdata", dm_rdata, 32'd0);
      checkOutput("t_c9_timeout_err", 32'(timeout_err), 32'd1);
      checkOutput("t_c9_mem_req", 32'(mem_req), 32'd0);
      dm_req = 1'b0;
      applyStimulus(0, 1, 32'h5A);
      checkOutput("t_c10_timeout_err", 32'(timeout_err), 32'd1);
      checkOutput("t_c10_dm_ack", 32'(dm_ack), 32'd0);
      applyStimulus(0, 0, 0);
      checkOutput("t_c11_timeout_err", 32'(timeout_err), 32'd1);
      checkOutput("t_c11_dm_ack", 32'(dm_ack), 32'd0);
      reset = 1'b1;
      #1;
      checkOutput("t_rst_timeout_err", 32'(timeout_err), 32'd0);
      applyStimulus(0, 0, 0);
      reset = 1'b0;
`else
      applyStimulus(1, 0, 0);
      checkOutput("t_c9_mem_req", 32'(mem_req), 32'd1);
      checkOutput("t_c9_dm_ack", 32'(dm_ack), 32'd0);
      checkOutput("t_c9_timeout_err", 32'(timeout_err), 32'd0);
      applyStimulus(0, 1, 32'h5A);
      applyStimulus(0, 0, 0);
      checkOutput("t_c11_dm_ack", 32'(dm_ack), 32'd1);
      checkOutput("t_c11_dm_rdata", dm_rdata, 32'h5A);
      checkOutput("t_c11_timeout_err", 32'(timeout_err), 32'd0);
      dm_req = 1'b0;
      applyStimulus(0, 0, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
